// File: rtl/fringe_pkg.sv
// Shared constants, state encoding and phase-increment helper for the fringe sequencer.
package fringe_pkg;

    localparam int N_STEPS_DEF = 8;
    localparam int N_FREQ_DEF  = 60;
    localparam int ARM_VS_DEF  = 3;
    localparam int STEP_W      = 3;
    localparam int FREQ_W      = 6;

    localparam longint unsigned PINC_FULL = 64'h1_0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2
    } fringe_state_e;

    // round(2^32 / (8*k)), rounding half up.
    function automatic logic [31:0] pinc_value(input int unsigned k);
        longint unsigned div;
        div = 64'(8 * k);
        return 32'((PINC_FULL + div / 2) / div);
    endfunction

endpackage

// File: rtl/fringe_pinc_rom.sv
// Phase-increment table: frequency index -> DDS increment, one-cycle registered read.
module fringe_pinc_rom
    import fringe_pkg::*;
#(
    parameter int N_FREQ = N_FREQ_DEF
) (
    input  logic              clk_25,
    input  logic              reset_n,
    input  logic [FREQ_W-1:0] addr_i,
    output logic [31:0]       data_o
);

    logic [31:0] rom [2**FREQ_W];
    logic [31:0] data_q;

    // Entries beyond the last fringe frequency read as zero.
    genvar gi;
    generate
        for (gi = 0; gi < 2**FREQ_W; gi++) begin : g_rom
            localparam logic [31:0] VAL = (gi < N_FREQ) ? pinc_value(gi + 1) : 32'd0;
            assign rom[gi] = VAL;
        end
    endgenerate

    always_ff @(posedge clk_25 or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= pinc_value(1);
        end else begin
            data_q <= rom[addr_i];
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/fringe_sequencer.sv
// Per-frame fringe sequencer: camera arming handshake, (step, frequency) counters
// and registered DDS phase controls, all on the pixel clock.
module fringe_sequencer
    import fringe_pkg::*;
#(
    parameter int N_STEPS = N_STEPS_DEF,
    parameter int N_FREQ  = N_FREQ_DEF,
    parameter int ARM_VS  = ARM_VS_DEF
) (
    input  logic              clk_25,
    input  logic              reset_n,
    input  logic              sync_vs,
    input  logic              sync_in_1,
    input  logic              sync_in_2,
    output logic [31:0]       phase_inc,
    output logic [31:0]       poff,
    output logic [STEP_W-1:0] step_idx,
    output logic [FREQ_W-1:0] freq_idx,
    output logic              sync_out_1,
    output logic              sync_out_2,
    output logic              seq_wrap,
    output logic              running
);

    localparam int                ARM_W     = $clog2(ARM_VS) + 1;
    localparam logic [ARM_W-1:0]  ARM_LAST  = ARM_W'(ARM_VS - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(N_STEPS - 1);
    localparam logic [FREQ_W-1:0] FREQ_LAST = FREQ_W'(N_FREQ - 1);

    logic [1:0]        trig_sync_q, rdy_sync_q;
    logic              trig_s, rdy_s;
    logic              vs_d_q, vs_fall;
    fringe_state_e     state_q, state_d;
    logic [ARM_W-1:0]  arm_cnt_q, arm_cnt_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [FREQ_W-1:0] freq_q, freq_d;
    logic              wrap_q, wrap_d;
    logic [31:0]       poff_q;
    logic              sync1_q, sync2_q, seq_wrap_q;

    assign trig_s  = trig_sync_q[1];
    assign rdy_s   = rdy_sync_q[1];
    assign vs_fall = vs_d_q & ~sync_vs;

    always_comb begin
        state_d   = state_q;
        arm_cnt_d = arm_cnt_q;
        step_d    = step_q;
        freq_d    = freq_q;
        wrap_d    = 1'b0;
        if (!trig_s) begin
            state_d   = ST_IDLE;
            arm_cnt_d = '0;
            step_d    = '0;
            freq_d    = '0;
        end else if (vs_fall) begin
            case (state_q)
                ST_IDLE: begin
                    if (rdy_s) begin
                        state_d   = ST_ARM;
                        arm_cnt_d = ARM_W'(1);
                    end
                end
                ST_ARM: begin
                    if (!rdy_s) begin
                        arm_cnt_d = '0;
                    end else if (arm_cnt_q == ARM_LAST) begin
                        state_d = ST_RUN;
                    end else begin
                        arm_cnt_d = arm_cnt_q + ARM_W'(1);
                    end
                end
                ST_RUN: begin
                    // A ready drop freezes the position so the sequence resumes where it stopped.
                    if (!rdy_s) begin
                        state_d   = ST_ARM;
                        arm_cnt_d = '0;
                    end else if (step_q == STEP_LAST) begin
                        step_d = '0;
                        if (freq_q == FREQ_LAST) begin
                            freq_d = '0;
                            wrap_d = 1'b1;
                        end else begin
                            freq_d = freq_q + FREQ_W'(1);
                        end
                    end else begin
                        step_d = step_q + STEP_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_25 or negedge reset_n) begin
        if (!reset_n) begin
            trig_sync_q <= '0;
            rdy_sync_q  <= '0;
            vs_d_q      <= 1'b0;
            state_q     <= ST_IDLE;
            arm_cnt_q   <= '0;
            step_q      <= '0;
            freq_q      <= '0;
            wrap_q      <= 1'b0;
            poff_q      <= '0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            seq_wrap_q  <= 1'b0;
        end else begin
            trig_sync_q <= {trig_sync_q[0], sync_in_1};
            rdy_sync_q  <= {rdy_sync_q[0], sync_in_2};
            vs_d_q      <= sync_vs;
            state_q     <= state_d;
            arm_cnt_q   <= arm_cnt_d;
            step_q      <= step_d;
            freq_q      <= freq_d;
            wrap_q      <= wrap_d;
            poff_q      <= {step_q, {(32 - STEP_W){1'b0}}};
            // Gating with trig_s keeps the strobe quiet on the edge where RUN is being abandoned.
            sync1_q     <= (state_q == ST_RUN) & trig_s & vs_d_q;
            sync2_q     <= (state_q == ST_RUN) & (step_q == '0);
            seq_wrap_q  <= wrap_q;
        end
    end

    fringe_pinc_rom #(
        .N_FREQ (N_FREQ)
    ) u_pinc_rom (
        .clk_25  (clk_25),
        .reset_n (reset_n),
        .addr_i  (freq_q),
        .data_o  (phase_inc)
    );

    assign poff       = poff_q;
    assign step_idx   = step_q;
    assign freq_idx   = freq_q;
    assign sync_out_1 = sync1_q;
    assign sync_out_2 = sync2_q;
    assign seq_wrap   = seq_wrap_q;
    assign running    = (state_q == ST_RUN);

endmodule

// File: tb/tb_fringe_sequencer.sv
// Directed bench for fringe_sequencer: arming, step/frequency roll, wrap, ready and trigger drops, reset.
module tb_fringe_sequencer;

    localparam int FRAME_LO = 6;

    logic        clk_25 = 1'b0;
    logic        reset_n, sync_vs, sync_in_1, sync_in_2;
    logic [31:0] phase_inc, poff;
    logic [2:0]  step_idx;
    logic [5:0]  freq_idx;
    logic        sync_out_1, sync_out_2, seq_wrap, running;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   wrap_cnt = 0;
    logic s1_seen = 1'b0;

    fringe_sequencer dut (
        .clk_25     (clk_25),
        .reset_n    (reset_n),
        .sync_vs    (sync_vs),
        .sync_in_1  (sync_in_1),
        .sync_in_2  (sync_in_2),
        .phase_inc  (phase_inc),
        .poff       (poff),
        .step_idx   (step_idx),
        .freq_idx   (freq_idx),
        .sync_out_1 (sync_out_1),
        .sync_out_2 (sync_out_2),
        .seq_wrap   (seq_wrap),
        .running    (running)
    );

    always #20 clk_25 = ~clk_25;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) begin
            $display("[TB] ok %s = %0d", tag, obs);
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One video frame: short VS pulse, then the active part sampled every cycle.
    task automatic frame();
        s1_seen = 1'b0;
        @(negedge clk_25) sync_vs = 1'b1;
        @(negedge clk_25) sync_vs = 1'b0;
        repeat (FRAME_LO) begin
            @(negedge clk_25);
            if (sync_out_1) s1_seen = 1'b1;
            if (seq_wrap)   wrap_cnt++;
        end
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    initial begin
        reset_n   = 1'b0;
        sync_vs   = 1'b0;
        sync_in_1 = 1'b0;
        sync_in_2 = 1'b0;
        repeat (3) @(negedge clk_25);
        chk("rst_phase_inc", phase_inc, 32'd536870912);
        chk("rst_poff", poff, 32'd0);
        chk("rst_step", 32'(step_idx), 32'd0);
        chk("rst_freq", 32'(freq_idx), 32'd0);
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_sync_out_2", 32'(sync_out_2), 32'd0);
        reset_n = 1'b1;

        // Arming: three VS falls with trigger and ready high.
        sync_in_1 = 1'b1;
        sync_in_2 = 1'b1;
        repeat (4) @(negedge clk_25);
        frame();
        chk("arm1_running", 32'(running), 32'd0);
        frame();
        chk("arm2_running", 32'(running), 32'd0);
        frame();
        chk("arm3_running", 32'(running), 32'd1);
        chk("arm3_step", 32'(step_idx), 32'd0);
        chk("arm3_sync_out_2", 32'(sync_out_2), 32'd1);
        frame();
        chk("run1_step", 32'(step_idx), 32'd1);
        chk("run1_poff", poff, 32'd536870912);
        chk("run1_sync_out_1", 32'(s1_seen), 32'd1);
        chk("run1_sync_out_2", 32'(sync_out_2), 32'd0);

        // Frequency roll after eight frames in total.
        frames(7);
        chk("roll_freq", 32'(freq_idx), 32'd1);
        chk("roll_step", 32'(step_idx), 32'd0);
        chk("roll_phase_inc", phase_inc, 32'd268435456);
        chk("roll_sync_out_2", 32'(sync_out_2), 32'd1);

        // Full sequence wrap: 472 more frames back to (0,0).
        wrap_cnt = 0;
        frames(8);
        chk("k3_freq", 32'(freq_idx), 32'd2);
        chk("k3_phase_inc", phase_inc, 32'd178956971);
        frames(456);
        chk("k60_freq", 32'(freq_idx), 32'd59);
        chk("k60_phase_inc", phase_inc, 32'd8947849);
        chk("prewrap_count", 32'(wrap_cnt), 32'd0);
        frames(8);
        chk("wrap_freq", 32'(freq_idx), 32'd0);
        chk("wrap_step", 32'(step_idx), 32'd0);
        chk("wrap_phase_inc", phase_inc, 32'd536870912);
        chk("wrap_pulse_count", 32'(wrap_cnt), 32'd1);

        // Ready drop: back to ARM with counters held, resume after three VS.
        frames(3);
        chk("pre_drop_step", 32'(step_idx), 32'd3);
        sync_in_2 = 1'b0;
        repeat (4) @(negedge clk_25);
        frame();
        chk("rdrop_running", 32'(running), 32'd0);
        chk("rdrop_step", 32'(step_idx), 32'd3);
        chk("rdrop_poff", poff, 32'd1610612736);
        sync_in_2 = 1'b1;
        repeat (4) @(negedge clk_25);
        frames(2);
        chk("rearm2_running", 32'(running), 32'd0);
        frame();
        chk("resume_running", 32'(running), 32'd1);
        chk("resume_step", 32'(step_idx), 32'd3);
        frame();
        chk("resume_adv_step", 32'(step_idx), 32'd4);
        chk("resume_adv_poff", poff, 32'd2147483648);

        // Trigger drop timed so the synchronised trigger falls with the VS fall edge.
        @(negedge clk_25) sync_in_1 = 1'b0;
        @(negedge clk_25) sync_vs = 1'b1;
        @(negedge clk_25) sync_vs = 1'b0;
        chk("tdrop_running_before", 32'(running), 32'd1);
        @(negedge clk_25);
        chk("tdrop_running", 32'(running), 32'd0);
        chk("tdrop_step", 32'(step_idx), 32'd0);
        chk("tdrop_freq", 32'(freq_idx), 32'd0);
        chk("tdrop_sync_out_1_a", 32'(sync_out_1), 32'd0);
        @(negedge clk_25);
        chk("tdrop_sync_out_1_b", 32'(sync_out_1), 32'd0);
        chk("tdrop_poff", poff, 32'd0);

        // Re-arm, run to (1,2), then reset asynchronously mid-frame.
        sync_in_1 = 1'b1;
        repeat (4) @(negedge clk_25);
        frames(3);
        chk("rearm_running", 32'(running), 32'd1);
        frames(10);
        chk("pre_rst_phase_inc", phase_inc, 32'd268435456);
        chk("pre_rst_poff", poff, 32'd1073741824);
        @(negedge clk_25);
        #7 reset_n = 1'b0;
        #1;
        chk("arst_phase_inc", phase_inc, 32'd536870912);
        chk("arst_poff", poff, 32'd0);
        chk("arst_step", 32'(step_idx), 32'd0);
        chk("arst_freq", 32'(freq_idx), 32'd0);
        chk("arst_running", 32'(running), 32'd0);
        chk("arst_sync_out_2", 32'(sync_out_2), 32'd0);
        repeat (2) @(negedge clk_25);
        reset_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
